// File: rtl/iso_power_ctrl.sv
// iso_power_ctrl: orders isolation clamps and power-switch enable for the vdd_sh domain.
module iso_power_ctrl #(
  parameter int ISO_SETUP   = 2,
  parameter int SETTLE      = 3,
  parameter int ACK_TIMEOUT = 16,
  parameter int CW          = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic sleep_req,
  input  logic wake_req,
  input  logic pwr_ack,
  input  logic err_clr,
  output logic iso1,
  output logic iso2,
  output logic iso3,
  output logic iso4,
  output logic pwr_en,
  output logic sleep_state,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [2:0] {S_ON, S_ISO_ON, S_PD_WAIT, S_OFF, S_PU_WAIT, S_SETTLE, S_ISO_OFF} state_t;
  localparam logic [CW-1:0] SETUP_M1 = CW'(ISO_SETUP - 1);
  localparam logic [CW-1:0] SET_M1   = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TO_M1    = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] TO       = CW'(ACK_TIMEOUT);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] iso_q, iso_n;
  logic pwr_en_n, sleep_n, busy_n, done_n, err_n, err_set;
  assign {iso4, iso3, iso2, iso1} = iso_q;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    iso_n    = iso_q;
    pwr_en_n = pwr_en;
    sleep_n  = sleep_state;
    busy_n   = busy;
    done_n   = 1'b0;
    err_set  = 1'b0;
    case (state)
      S_ON: if (sleep_req) begin
        state_n  = S_ISO_ON;
        iso_n[0] = 1'b1;
        busy_n   = 1'b1;
        cnt_n    = '0;
      end
      // Clamp bits double as the sub-phase: set-up counting starts once iso4 is up.
      S_ISO_ON: if (!iso_q[1]) iso_n[1] = 1'b1;
        else if (!iso_q[2]) iso_n[2] = 1'b1;
        else if (!iso_q[3]) iso_n[3] = 1'b1;
        else if (cnt == SETUP_M1) begin
          pwr_en_n = 1'b0;
          state_n  = S_PD_WAIT;
          cnt_n    = '0;
        end else cnt_n = cnt + 1'b1;
      S_PD_WAIT: if (!pwr_ack || cnt == TO_M1) begin
        state_n = S_OFF;
        sleep_n = 1'b1;
        busy_n  = 1'b0;
        err_set = pwr_ack;
      end else cnt_n = cnt + 1'b1;
      S_OFF: if (wake_req) begin
        state_n  = S_PU_WAIT;
        pwr_en_n = 1'b1;
        sleep_n  = 1'b0;
        busy_n   = 1'b1;
        cnt_n    = '0;
      end
      // Counter saturates at the timeout so err is raised once and a late ack still proceeds.
      S_PU_WAIT: if (pwr_ack) begin
        state_n = S_SETTLE;
        cnt_n   = '0;
      end else if (cnt != TO) begin
        cnt_n   = cnt + 1'b1;
        err_set = (cnt == TO_M1);
      end
      S_SETTLE: if (cnt == SET_M1) begin
        iso_n[3] = 1'b0;
        state_n  = S_ISO_OFF;
      end else cnt_n = cnt + 1'b1;
      S_ISO_OFF: if (iso_q[2]) iso_n[2] = 1'b0;
        else if (iso_q[1]) iso_n[1] = 1'b0;
        else begin
          iso_n[0] = 1'b0;
          state_n  = S_ON;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end
      default: state_n = S_ON;
    endcase
    err_n = err_set | (err & ~err_clr);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_ON;
      cnt         <= '0;
      iso_q       <= '0;
      pwr_en      <= 1'b1;
      sleep_state <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      iso_q       <= iso_n;
      pwr_en      <= pwr_en_n;
      sleep_state <= sleep_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
    end
  end
endmodule

// File: tb/tb_iso_power_ctrl.sv
// tb_iso_power_ctrl: vector table, directed corner sequences and random run against a timeline model.
module tb_iso_power_ctrl;
  localparam int S = 2, ST = 3, T = 16;
  logic clock = 1'b0;
  logic reset, sleep_req, wake_req, pwr_ack, err_clr;
  logic iso1, iso2, iso3, iso4, pwr_en, sleep_state, busy, done, err;
  always #5 clock = ~clock;
  iso_power_ctrl #(.ISO_SETUP(S), .SETTLE(ST), .ACK_TIMEOUT(T), .CW(5)) dut (
    .clock(clock), .reset(reset), .sleep_req(sleep_req), .wake_req(wake_req),
    .pwr_ack(pwr_ack), .err_clr(err_clr), .iso1(iso1), .iso2(iso2), .iso3(iso3),
    .iso4(iso4), .pwr_en(pwr_en), .sleep_state(sleep_state), .busy(busy),
    .done(done), .err(err)
  );
  wire [8:0] dut_o = {iso4, iso3, iso2, iso1, pwr_en, sleep_state, busy, done, err};
  int checks = 0, errors = 0;
  // Model: sequences are timelines measured from the request edge (k) and the first good ack (wa).
  typedef enum {M_ON, M_DOWN, M_OFF, M_UP} mode_t;
  mode_t mode;
  int k, wa;
  logic [3:0] m_iso;
  logic m_pwr, m_slp, m_bsy, m_dn, m_er;
  task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  task automatic model_edge();
    logic set;
    set = 1'b0;
    if (reset) begin
      mode = M_ON; m_iso = 4'b0000; m_pwr = 1'b1; m_slp = 1'b0; m_bsy = 1'b0; m_dn = 1'b0; m_er = 1'b0;
    end else begin
      m_dn = 1'b0;
      case (mode)
        M_ON: if (sleep_req) begin
          mode = M_DOWN; k = 0; m_iso = 4'b0001; m_bsy = 1'b1;
        end
        M_DOWN: begin
          k++;
          for (int i = 0; i < 4; i++) m_iso[i] = (k >= i);
          m_pwr = (k < 3 + S);
          if (k >= 4 + S && (!pwr_ack || k == 3 + S + T)) begin
            set = pwr_ack; mode = M_OFF; m_slp = 1'b1; m_bsy = 1'b0;
          end
        end
        M_OFF: if (wake_req) begin
          mode = M_UP; k = 0; wa = -1; m_pwr = 1'b1; m_slp = 1'b0; m_bsy = 1'b1;
        end
        default: begin
          k++;
          if (wa < 0) begin
            if (pwr_ack) wa = k;
            else if (k == T) set = 1'b1;
          end else begin
            for (int i = 0; i < 4; i++) if (k - wa >= ST + 3 - i) m_iso[i] = 1'b0;
            if (k - wa == ST + 3) begin
              mode = M_ON; m_dn = 1'b1; m_bsy = 1'b0;
            end
          end
        end
      endcase
      m_er = set | (m_er & ~err_clr);
    end
  endtask
  task automatic drive(logic r, logic s, logic w, logic a, logic c);
    {reset, sleep_req, wake_req, pwr_ack, err_clr} = {r, s, w, a, c};
  endtask
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    chk("model", dut_o, {m_iso, m_pwr, m_slp, m_bsy, m_dn, m_er});
    chk("iso_invariant", {8'd0, pwr_en | (&{iso4, iso3, iso2, iso1})}, 9'd1);
  endtask
  typedef struct packed {logic [4:0] in; logic [8:0] exp;} vec_t;
  vec_t vec [14];
  initial begin
    // in = {reset,sleep,wake,ack,clr}; exp = {iso4..iso1,pwr_en,sleep_state,busy,done,err}
    vec[0]  = 14'b10010_0000_1_0_0_0_0;
    vec[1]  = 14'b00010_0000_1_0_0_0_0;
    vec[2]  = 14'b00010_0000_1_0_0_0_0;
    vec[3]  = 14'b00010_0000_1_0_0_0_0;
    vec[4]  = 14'b00110_0000_1_0_0_0_0;
    vec[5]  = 14'b00110_0000_1_0_0_0_0;
    vec[6]  = 14'b01010_0001_1_0_1_0_0;
    vec[7]  = 14'b00010_0011_1_0_1_0_0;
    vec[8]  = 14'b00010_0111_1_0_1_0_0;
    vec[9]  = 14'b00010_1111_1_0_1_0_0;
    vec[10] = 14'b00010_1111_1_0_1_0_0;
    vec[11] = 14'b00010_1111_0_0_1_0_0;
    vec[12] = 14'b00010_1111_0_0_1_0_0;
    vec[13] = 14'b00000_1111_0_1_0_0_0;
    for (int i = 0; i < 14; i++) begin
      {reset, sleep_req, wake_req, pwr_ack, err_clr} = vec[i].in;
      tick();
      chk($sformatf("vec%0d", i), dut_o, vec[i].exp);
    end
    for (int n = 0; n < 12; n++) begin
      drive(0, 0, n == 0, n >= 4, 0);
      tick();
      if (n == 6)  chk("pu_w6", dut_o, 9'b1111_1_0_1_0_0);
      if (n == 7)  chk("pu_iso4_fall", dut_o, 9'b0111_1_0_1_0_0);
      if (n == 10) chk("pu_iso1_fall_done", dut_o, 9'b0000_1_0_0_1_0);
      if (n == 11) chk("pu_done_pulse", dut_o, 9'b0000_1_0_0_0_0);
    end
    for (int n = 0; n < 23; n++) begin
      drive(0, n == 0, 0, 1, n == 22);
      tick();
      if (n == 20) chk("pd_to_e20", dut_o, 9'b1111_0_0_1_0_0);
      if (n == 21) chk("pd_to_off_err", dut_o, 9'b1111_0_1_0_0_1);
      if (n == 22) chk("err_clr", dut_o, 9'b1111_0_1_0_0_0);
    end
    for (int n = 0; n < 27; n++) begin
      drive(0, 0, n == 0, n >= 20, 0);
      tick();
      if (n == 15) chk("pu_to_w15", dut_o, 9'b1111_1_0_1_0_0);
      if (n == 16) chk("pu_to_err", dut_o, 9'b1111_1_0_1_0_1);
      if (n == 26) chk("pu_late_ack_done", dut_o, 9'b0000_1_0_0_1_1);
    end
    drive(0, 0, 0, 1, 1);
    tick();
    for (int n = 0; n < 5; n++) begin
      drive(n == 3, 1, 0, 1, 0);
      tick();
      if (n == 2) chk("rst_pre", dut_o, 9'b0111_1_0_1_0_0);
      if (n == 3) chk("rst_mid", dut_o, 9'b0000_1_0_0_0_0);
      if (n == 4) chk("rst_restart", dut_o, 9'b0001_1_0_1_0_0);
    end
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 9) < 8) ? m_pwr : ~m_pwr, $urandom_range(0, 19) == 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
